// File: rtl/meas_delay_stat.sv
// Windowed delay statistics: skips NSKIP settling samples after a start, accumulates
// NSAMPLE scaled samples, then publishes min/max/mean/peak-to-peak until the next start.
module meas_delay_stat #(
  parameter int unsigned NSAMPLE = 64,
  parameter int unsigned NSKIP   = 4,
  parameter real         scale   = 1.0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  real         delay_in,
  input  logic        delay_vld,
  output logic        busy,
  output logic        done,
  output logic [15:0] cnt,
  output real         dmin,
  output real         dmax,
  output real         dmean,
  output real         dpp
);

  localparam int unsigned CW = 16;
  localparam real MIN_INIT = 1.0e30;
  localparam real MAX_INIT = -1.0e30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] skip_cnt;
  real           sum;
  real           run_min;
  real           run_max;

  logic [CW:0]   skip_cnt_nxt;
  logic [CW:0]   cnt_nxt;
  real           s;
  real           sum_nxt;
  real           min_nxt;
  real           max_nxt;

  // Candidate running statistics including the sample presented this cycle.
  always_comb begin
    skip_cnt_nxt = (CW+1)'(skip_cnt) + (CW+1)'(1);
    cnt_nxt      = (CW+1)'(cnt) + (CW+1)'(1);
    s            = delay_in * scale;
    sum_nxt      = sum + s;
    min_nxt      = (s < run_min) ? s : run_min;
    max_nxt      = (s > run_max) ? s : run_max;
  end

  // Window FSM with registered status and published statistics.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      skip_cnt <= '0;
      sum      <= 0.0;
      run_min  <= 0.0;
      run_max  <= 0.0;
      dmin     <= 0.0;
      dmax     <= 0.0;
      dmean    <= 0.0;
      dpp      <= 0.0;
    end else if (start) begin
      // Start from any state restarts the window; a coincident strobe is dropped.
      state    <= (NSKIP > 0) ? SKIP : ACC;
      busy     <= 1'b1;
      done     <= 1'b0;
      cnt      <= '0;
      skip_cnt <= '0;
      sum      <= 0.0;
      run_min  <= MIN_INIT;
      run_max  <= MAX_INIT;
    end else begin
      case (state)
        SKIP: begin
          if (delay_vld) begin
            skip_cnt <= skip_cnt_nxt[CW-1:0];
            if (skip_cnt_nxt == (CW+1)'(NSKIP)) begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (delay_vld) begin
            sum     <= sum_nxt;
            run_min <= min_nxt;
            run_max <= max_nxt;
            cnt     <= cnt_nxt[CW-1:0];
            // Final sample: publish with zero extra latency.
            if (cnt_nxt == (CW+1)'(NSAMPLE)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              dmin  <= min_nxt;
              dmax  <= max_nxt;
              dmean <= sum_nxt / real'(NSAMPLE);
              dpp   <= max_nxt - min_nxt;
            end
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_meas_delay_stat.sv
// Directed self-checking bench for meas_delay_stat using three differently
// parameterised instances on a shared clock and reset.
module tb_meas_delay_stat;

  logic clk;
  logic rstn;

  logic start0, vld0, start1, vld1, start2, vld2;
  real  din0, din1, din2;

  logic        busy0, done0, busy1, done1, busy2, done2;
  logic [15:0] cnt0, cnt1, cnt2;
  real         dmin0, dmax0, dmean0, dpp0;
  real         dmin1, dmax1, dmean1, dpp1;
  real         dmin2, dmax2, dmean2, dpp2;

  int n_chk;
  int n_pass;

  meas_delay_stat #(.NSAMPLE(4), .NSKIP(2), .scale(1.0e12)) u0 (
    .clk(clk), .rstn(rstn), .start(start0), .delay_in(din0), .delay_vld(vld0),
    .busy(busy0), .done(done0), .cnt(cnt0),
    .dmin(dmin0), .dmax(dmax0), .dmean(dmean0), .dpp(dpp0)
  );

  meas_delay_stat #(.NSAMPLE(4), .NSKIP(0), .scale(1.0e12)) u1 (
    .clk(clk), .rstn(rstn), .start(start1), .delay_in(din1), .delay_vld(vld1),
    .busy(busy1), .done(done1), .cnt(cnt1),
    .dmin(dmin1), .dmax(dmax1), .dmean(dmean1), .dpp(dpp1)
  );

  meas_delay_stat #(.NSAMPLE(2), .NSKIP(0), .scale(1.0)) u2 (
    .clk(clk), .rstn(rstn), .start(start2), .delay_in(din2), .delay_vld(vld2),
    .busy(busy2), .done(done2), .cnt(cnt2),
    .dmin(dmin2), .dmax(dmax2), .dmean(dmean2), .dpp(dpp2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input real obs, input real exp);
    real diff;
    n_chk++;
    diff = (obs > exp) ? obs - exp : exp - obs;
    if (diff <= 1.0e-9 * (1.0 + ((exp < 0.0) ? -exp : exp))) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %g expected %g", tag, obs, exp);
    end
  endtask

  // One-cycle drive of an instance's inputs, applied at negedge so the next
  // posedge samples it; returns at the following negedge ready for checking.
  task automatic pulse(input int i, input logic st, input logic v, input real d);
    @(negedge clk);
    case (i)
      0: begin start0 = st; vld0 = v; din0 = d; end
      1: begin start1 = st; vld1 = v; din1 = d; end
      default: begin start2 = st; vld2 = v; din2 = d; end
    endcase
    @(negedge clk);
    case (i)
      0: begin start0 = 1'b0; vld0 = 1'b0; end
      1: begin start1 = 1'b0; vld1 = 1'b0; end
      default: begin start2 = 1'b0; vld2 = 1'b0; end
    endcase
  endtask

  task automatic check_u0(input string tag, input real mn, input real mx,
                          input real mean, input real pp);
    check({tag, "_dmin"},  dmin0,  mn);
    check({tag, "_dmax"},  dmax0,  mx);
    check({tag, "_dmean"}, dmean0, mean);
    check({tag, "_dpp"},   dpp0,   pp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    start0 = 0; vld0 = 0; din0 = 0.0;
    start1 = 0; vld1 = 0; din1 = 0.0;
    start2 = 0; vld2 = 0; din2 = 0.0;
    rstn   = 0;
    repeat (3) @(negedge clk);
    rstn = 1;

    // Reset then idle: strobes without a start do nothing.
    for (int k = 0; k < 10; k++) pulse(0, 1'b0, 1'b1, 5.0e-12);
    check("rst_busy", real'(busy0), 0.0);
    check("rst_done", real'(done0), 0.0);
    check("rst_cnt",  real'(cnt0),  0.0);
    check_u0("rst", 0.0, 0.0, 0.0, 0.0);
    check("rst_u1_dmean", dmean1, 0.0);
    check("rst_u2_done",  real'(done2), 0.0);

    // Nominal window: two skipped, then 10,12,11,15.
    pulse(0, 1'b1, 1'b0, 0.0);
    check("nom_busy", real'(busy0), 1.0);
    check("nom_cnt0", real'(cnt0), 0.0);
    pulse(0, 1'b0, 1'b1, 9.0e-12);
    pulse(0, 1'b0, 1'b1, 9.0e-12);
    check("nom_cnt_after_skip", real'(cnt0), 0.0);
    pulse(0, 1'b0, 1'b1, 10.0e-12);
    pulse(0, 1'b0, 1'b1, 12.0e-12);
    pulse(0, 1'b0, 1'b1, 11.0e-12);
    check("nom_cnt3", real'(cnt0), 3.0);
    check("nom_done_early", real'(done0), 0.0);
    check("nom_dmean_held", dmean0, 0.0);
    pulse(0, 1'b0, 1'b1, 15.0e-12);
    check("nom_done", real'(done0), 1.0);
    check("nom_busy_off", real'(busy0), 0.0);
    check("nom_cnt", real'(cnt0), 4.0);
    check_u0("nom", 10.0, 15.0, 12.0, 5.0);

    // Hold: strobes in DONE are ignored.
    for (int k = 0; k < 5; k++) pulse(0, 1'b0, 1'b1, 99.0e-12);
    check("hold_done", real'(done0), 1.0);
    check("hold_cnt", real'(cnt0), 4.0);
    check_u0("hold", 10.0, 15.0, 12.0, 5.0);

    // Re-arm: done drops, previous results held until the new window completes.
    pulse(0, 1'b1, 1'b0, 0.0);
    check("rearm_done", real'(done0), 0.0);
    check("rearm_busy", real'(busy0), 1.0);
    check_u0("rearm", 10.0, 15.0, 12.0, 5.0);
    pulse(0, 1'b0, 1'b1, 50.0e-12);
    pulse(0, 1'b0, 1'b1, 50.0e-12);
    pulse(0, 1'b0, 1'b1, 1.0e-12);
    pulse(0, 1'b0, 1'b1, 6.0e-12);
    pulse(0, 1'b0, 1'b1, 2.0e-12);
    check_u0("rearm_mid", 10.0, 15.0, 12.0, 5.0);
    pulse(0, 1'b0, 1'b1, 3.0e-12);
    check("rearm_done2", real'(done0), 1.0);
    check_u0("rearm_new", 1.0, 6.0, 3.0, 5.0);

    // Restart mid-window on the NSKIP=0 instance.
    pulse(1, 1'b1, 1'b0, 0.0);
    check("rs_busy", real'(busy1), 1.0);
    pulse(1, 1'b0, 1'b1, 50.0e-12);
    pulse(1, 1'b0, 1'b1, 70.0e-12);
    check("rs_cnt2", real'(cnt1), 2.0);
    pulse(1, 1'b1, 1'b0, 0.0);
    check("rs_cnt_clr", real'(cnt1), 0.0);
    for (int k = 0; k < 4; k++) pulse(1, 1'b0, 1'b1, 1.0e-12);
    check("rs_done", real'(done1), 1.0);
    check("rs_dmean", dmean1, 1.0);
    check("rs_dpp", dpp1, 0.0);
    check("rs_dmin", dmin1, 1.0);
    check("rs_dmax", dmax1, 1.0);

    // Start and strobe together: the sample is dropped.
    pulse(2, 1'b1, 1'b1, 100.0);
    check("sim_cnt", real'(cnt2), 0.0);
    check("sim_busy", real'(busy2), 1.0);
    pulse(2, 1'b0, 1'b1, 2.0);
    check("sim_done_early", real'(done2), 0.0);
    pulse(2, 1'b0, 1'b1, 4.0);
    check("sim_done", real'(done2), 1.0);
    check("sim_dmin", dmin2, 2.0);
    check("sim_dmax", dmax2, 4.0);
    check("sim_dmean", dmean2, 3.0);
    check("sim_dpp", dpp2, 2.0);

    // Reset during the 3rd accumulated sample of a window.
    pulse(0, 1'b1, 1'b0, 0.0);
    pulse(0, 1'b0, 1'b1, 5.0e-12);
    pulse(0, 1'b0, 1'b1, 5.0e-12);
    pulse(0, 1'b0, 1'b1, 7.0e-12);
    pulse(0, 1'b0, 1'b1, 8.0e-12);
    @(negedge clk);
    rstn = 1'b0;
    vld0 = 1'b1;
    din0 = 9.0e-12;
    @(negedge clk);
    rstn = 1'b1;
    vld0 = 1'b0;
    check("mrst_busy", real'(busy0), 0.0);
    check("mrst_done", real'(done0), 0.0);
    check("mrst_cnt", real'(cnt0), 0.0);
    check_u0("mrst", 0.0, 0.0, 0.0, 0.0);
    pulse(0, 1'b0, 1'b1, 9.0e-12);
    pulse(0, 1'b0, 1'b1, 9.0e-12);
    check("mrst_done_after", real'(done0), 0.0);
    check("mrst_cnt_after", real'(cnt0), 0.0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
